// File: rtl/apb_arb_pkg.sv
// Shared types and default sizing for the APB request arbiter.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } arb_state_e;

  localparam int DEF_NUM_REQ = 2;
  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_TIMEOUT = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: searches upward from the requester after last_grant_i.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      last_grant_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IW-1:0]      idx_o,
  output logic               any_o
);

  int          cand;
  logic [IW-1:0] cand_idx;

  always_comb begin
    grant_o  = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand     = (int'(last_grant_i) + k) % NUM_REQ;
      cand_idx = IW'(cand);
      if (!any_o && req_i[cand_idx]) begin
        any_o             = 1'b1;
        grant_o[cand_idx] = 1'b1;
        idx_o             = cand_idx;
      end
    end
  end

endmodule

// File: rtl/apb_req_arbiter.sv
// Shares one APB master port between NUM_REQ requesters with round-robin grant and ACCESS timeout.
// Handshake: req_valid is held until req_ack pulses; req_done/req_err/req_rdata are a one-cycle completion.
module apb_req_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                      pclk,
  input  logic                      prst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ack,
  output logic [NUM_REQ-1:0]        req_done,
  output logic                      req_err,
  output logic [DATA_W-1:0]         req_rdata,
  output logic                      psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [ADDR_W-1:0]         paddr,
  output logic [DATA_W-1:0]         pwdata,
  input  logic                      pready,
  input  logic [DATA_W-1:0]         prdata,
  output arb_state_e                dbg_state
);

  localparam int IW = $clog2(NUM_REQ);

  arb_state_e          state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                write_q, write_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [IW-1:0]       gidx_q, gidx_d;
  logic [IW-1:0]       last_q, last_d;
  logic [7:0]          wait_q, wait_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic [NUM_REQ-1:0]  done_q, done_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic [NUM_REQ-1:0]  grant;
  logic [IW-1:0]       grant_idx;
  logic                grant_any;
  logic                timeout_hit;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                sel_write;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_rr (
    .req_i        (req_valid),
    .last_grant_i (last_q),
    .grant_o      (grant),
    .idx_o        (grant_idx),
    .any_o        (grant_any)
  );

  // Abort on the cycle that would have been the TIMEOUT-th wait; pready wins a tie.
  assign timeout_hit = (state_q == ACCESS) && !pready && (wait_q == 8'(TIMEOUT - 1));

  always_ff @(posedge pclk) begin
    if (prst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      gidx_q  <= '0;
      last_q  <= IW'(NUM_REQ - 1);
      wait_q  <= '0;
      ack_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      gidx_q  <= gidx_d;
      last_q  <= last_d;
      wait_q  <= wait_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_any) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (pready || timeout_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_write = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
        sel_write = req_write[i];
      end
    end
  end

  always_comb begin
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    gidx_d  = gidx_q;
    last_d  = last_q;
    wait_d  = wait_q;
    ack_d   = '0;
    done_d  = '0;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    if (state_q == IDLE && grant_any) begin
      addr_d  = sel_addr;
      write_d = sel_write;
      wdata_d = sel_wdata;
      gidx_d  = grant_idx;
      last_d  = grant_idx;
      wait_d  = '0;
      ack_d   = grant;
    end else if (state_q == ACCESS) begin
      if (pready) begin
        done_d[gidx_q] = 1'b1;
        wait_d         = '0;
        if (!write_q) rdata_d = prdata;
      end else if (timeout_hit) begin
        done_d[gidx_q] = 1'b1;
        err_d          = 1'b1;
        rdata_d        = '0;
        wait_d         = '0;
      end else begin
        wait_d = wait_q + 8'd1;
      end
    end
  end

  always_comb begin
    psel      = (state_q != IDLE);
    penable   = (state_q == ACCESS);
    paddr     = psel ? addr_q  : '0;
    pwrite    = psel ? write_q : 1'b0;
    pwdata    = psel ? wdata_q : '0;
    req_ack   = ack_q;
    req_done  = done_q;
    req_err   = err_q;
    req_rdata = rdata_q;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter: completions checked against an expected queue.
module tb_apb_req_arbiter;
  import apb_arb_pkg::*;

  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 4;
  localparam int W       = 1 + DATA_W + NUM_REQ;

  logic                      pclk;
  logic                      prst;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_ack;
  logic [NUM_REQ-1:0]        req_done;
  logic                      req_err;
  logic [DATA_W-1:0]         req_rdata;
  logic                      psel, penable, pwrite;
  logic [ADDR_W-1:0]         paddr;
  logic [DATA_W-1:0]         pwdata;
  logic                      pready;
  logic [DATA_W-1:0]         prdata;
  arb_state_e                dbg_state;

  logic [W-1:0]       exp_q[$];
  logic [NUM_REQ-1:0] gnt_q[$];
  logic [DATA_W-1:0]  rdata_model;
  int checks;
  int failures;

  apb_req_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .pclk(pclk), .prst(prst),
    .req_valid(req_valid), .req_addr(req_addr), .req_write(req_write), .req_wdata(req_wdata),
    .req_ack(req_ack), .req_done(req_done), .req_err(req_err), .req_rdata(req_rdata),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pready(pready), .prdata(prdata), .dbg_state(dbg_state)
  );

  // Clock and reset
  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge pclk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ctl"},   {psel, penable, pwrite}, 3'b000);
    check({tag, "_addr"},  paddr, 0);
    check({tag, "_wdata"}, pwdata, 0);
    check({tag, "_ack"},   req_ack, 0);
    check({tag, "_done"},  req_done, 0);
    check({tag, "_err"},   req_err, 0);
    check({tag, "_rdata"}, req_rdata, 0);
  endtask

  // Driver for one full transfer; expected completion is queued before the request is raised.
  task automatic run_xfer(input int r, input logic [31:0] addr, input logic wr,
                          input logic [31:0] wd, input int waits, input logic [31:0] rd,
                          input bit tmo, input bit noise);
    logic [NUM_REQ-1:0] oh;
    logic [W-1:0]       got;
    logic [W-1:0]       exp_e;
    int k;
    oh = '0;
    oh[r] = 1'b1;
    if (tmo) rdata_model = '0;
    else if (!wr) rdata_model = rd;
    exp_q.push_back({tmo, rdata_model, oh});

    req_valid = oh;
    req_addr[r*ADDR_W +: ADDR_W]  = addr;
    req_write[r]                  = wr;
    req_wdata[r*DATA_W +: DATA_W] = wd;
    tick();
    check("ack", req_ack, oh);
    check("setup_ctl", {psel, penable}, 2'b10);
    check("setup_addr", paddr, addr);
    check("setup_write", pwrite, wr);
    check("setup_wdata", pwdata, wd);
    check("setup_state", dbg_state, SETUP);
    req_valid = '0;
    tick();

    k = 0;
    while (k < 64) begin
      check("access_ctl", {psel, penable}, 2'b11);
      check("access_addr", paddr, addr);
      pready = !tmo && (k == waits);
      prdata = pready ? rd : $urandom();
      if (noise) req_valid[1-r] = 1'($urandom_range(0, 1));
      tick();
      if (req_done != '0) break;
      k++;
    end
    pready    = 1'b0;
    req_valid = '0;

    check("latency", k, tmo ? TIMEOUT - 1 : waits);
    got = {req_err, req_rdata, req_done};
    if (exp_q.size() > 0) exp_e = exp_q.pop_front();
    else exp_e = '1;
    check("done", got, exp_e);
    check("done_idle_ctl", {psel, penable}, 2'b00);
    check("done_idle_addr", paddr, 0);
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rdata_model = '0;
    prst        = 1'b1;
    req_valid   = '0;
    req_addr    = '0;
    req_write   = '0;
    req_wdata   = '0;
    pready      = 1'b0;
    prdata      = '0;

    repeat (3) tick();
    check_outputs_zero("reset");
    check("reset_state", dbg_state, IDLE);
    prst = 1'b0;
    tick();
    check_outputs_zero("post_reset");

    // Single write, read with wait states, write holding rdata, timeout
    run_xfer(0, 32'h10, 1'b1, 32'hA5A5_0001, 0, 32'h0, 1'b0, 1'b0);
    run_xfer(1, 32'h20, 1'b0, 32'h1111_2222, 3, 32'hDEAD_BEEF, 1'b0, 1'b1);
    run_xfer(0, 32'h24, 1'b1, 32'h3333_4444, 1, 32'h0, 1'b0, 1'b0);
    run_xfer(1, 32'h30, 1'b0, 32'h0, 0, 32'h5555_6666, 1'b1, 1'b0);

    for (int i = 0; i < 4; i++) begin
      run_xfer($urandom_range(0, 1), $urandom(), 1'($urandom_range(0, 1)), $urandom(),
               $urandom_range(0, 2), $urandom(), 1'b0, 1'b1);
    end

    // Contention: both requesters held high, expect alternation starting after the last grant
    run_xfer(1, 32'h50, 1'b1, 32'h0, 0, 32'h0, 1'b0, 1'b0);
    gnt_q.push_back(2'b01);
    gnt_q.push_back(2'b10);
    gnt_q.push_back(2'b01);
    gnt_q.push_back(2'b10);
    req_write = 2'b11;
    req_valid = 2'b11;
    pready    = 1'b1;
    for (int n = 0; n < 4; n++) begin
      int w;
      w = 0;
      do begin
        tick();
        w++;
      end while (req_ack == '0 && w < 8);
      check("contention_ack", req_ack, gnt_q.pop_front());
    end
    req_valid = '0;
    tick();
    tick();
    check("contention_last_done", req_done, 2'b10);
    pready = 1'b0;
    tick();

    // Reset during ACCESS: no completion, and round-robin pointer returns to requester 0
    req_valid = 2'b01;
    req_addr[0 +: ADDR_W] = 32'h40;
    req_write[0] = 1'b0;
    tick();
    check("rst_ack", req_ack, 2'b01);
    req_valid = '0;
    tick();
    check("rst_access", dbg_state, ACCESS);
    prst = 1'b1;
    tick();
    prst = 1'b0;
    check_outputs_zero("mid_reset");
    check("mid_reset_state", dbg_state, IDLE);
    tick();
    check("post_reset_done", req_done, 0);
    check("post_reset_sel", psel, 0);
    req_valid = 2'b11;
    tick();
    check("post_reset_grant", req_ack, 2'b01);
    req_valid = '0;
    pready    = 1'b1;
    tick();
    tick();
    check("post_reset_xfer_done", {req_err, req_done}, 3'b001);
    pready = 1'b0;

    check("exp_q_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
